// File: rtl/sram_playback.sv
// SRAM playback controller: reads a block of samples from the capture SRAM and
// streams them to a downstream consumer over a valid/ready handshake.
module sram_playback #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] sram_data,
    output logic              nce,
    output logic              noe,
    output logic              nwe,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_PRESENT,
        S_FINISH
    } state_t;

    localparam logic [3:0]      WAIT_LOAD = 4'(RD_WAIT - 1);
    localparam logic [ADDR_W:0] REM_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] data_q, data_d;

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        data_d    = data_q;
        nce       = 1'b1;
        noe       = 1'b1;
        out_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = len;
                    state_d = (len == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP: begin
                nce     = 1'b0;
                wait_d  = WAIT_LOAD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                nce = 1'b0;
                noe = 1'b0;
                if (wait_q == 4'd0) begin
                    data_d  = sram_data;
                    state_d = S_PRESENT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rem_d   = rem_q - REM_ONE;
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = (rem_q == REM_ONE) ? S_FINISH : S_SETUP;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
        end
    end

    assign address  = addr_q;
    assign out_data = data_q;
    assign busy     = (state_q != S_IDLE);
    assign nwe      = 1'b1;

endmodule

// File: tb/tb_sram_playback.sv
// Directed testbench for sram_playback with a behavioural SRAM and handshake monitor.
module tb_sram_playback;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              CLK;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] sram_data;
    logic              nce, noe, nwe;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready, busy, done;

    sram_playback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(2)) dut (
        .CLK(CLK), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .address(address), .sram_data(sram_data), .nce(nce), .noe(noe), .nwe(nwe),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    assign sram_data = (nce === 1'b0 && noe === 1'b0) ? mem[address] : 'x;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    int done_cnt    = 0;
    int nce_low_cnt = 0;
    int strobe_viol = 0;
    logic [DATA_W-1:0] acc_d[$];
    logic [ADDR_W-1:0] acc_a[$];

    // Handshake scoreboard and strobe monitors
    always @(posedge CLK) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (nce === 1'b0) nce_low_cnt <= nce_low_cnt + 1;
        if (nce === 1'b1 && noe === 1'b0) strobe_viol <= strobe_viol + 1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            acc_d.push_back(out_data);
            acc_a.push_back(address);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("valid_seen", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int n;
        int q0, d0, c0;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i + 'h10);

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        out_ready = 1'b1;
        #2;
        check("rst_nce", 32'(nce), 32'd1);
        check("rst_noe", 32'(noe), 32'd1);
        check("rst_nwe", 32'(nwe), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Basic run
        q0 = acc_d.size();
        d0 = done_cnt;
        start_run(11'h000, 12'd4);
        check("basic_setup_busy", 32'(busy), 32'd1);
        check("basic_setup_nce", 32'(nce), 32'd0);
        check("basic_setup_noe", 32'(noe), 32'd1);
        step();
        check("basic_access_noe", 32'(noe), 32'd0);
        check("basic_access_nce", 32'(nce), 32'd0);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("basic_first_latency", 32'(n), 32'd3);
        check("basic_data0", 32'(out_data), 32'h10);
        check("basic_present_nce", 32'(nce), 32'd1);
        check("basic_present_noe", 32'(noe), 32'd1);
        for (int k = 1; k < 4; k++) begin
            step();
            check("basic_gap_valid", 32'(out_valid), 32'd0);
            wait_valid(n);
            check("basic_period", 32'(n + 1), 32'd4);
            check("basic_data", 32'(out_data), 32'(8'h10 + k));
        end
        step();
        check("basic_done", 32'(done), 32'd1);
        check("basic_finish_busy", 32'(busy), 32'd1);
        check("basic_finish_valid", 32'(out_valid), 32'd0);
        step();
        check("basic_done_low", 32'(done), 32'd0);
        check("basic_busy_low", 32'(busy), 32'd0);
        check("basic_addr_hold", 32'(address), 32'h004);
        check("basic_done_count", 32'(done_cnt - d0), 32'd1);
        check("basic_accepted", 32'(acc_d.size() - q0), 32'd4);
        for (int k = 0; k < 4; k++) check("basic_sb_data", 32'(acc_d[q0 + k]), 32'(8'h10 + k));

        // Backpressure on sample 2
        q0 = acc_d.size();
        start_run(11'h000, 12'd4);
        wait_valid(n);
        check("bp_data0", 32'(out_data), 32'h10);
        step();
        wait_valid(n);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data), 32'h11);
            check("bp_hold_noe", 32'(noe), 32'd1);
        end
        out_ready = 1'b1;
        step();
        wait_valid(n);
        check("bp_data2", 32'(out_data), 32'h12);
        step();
        wait_valid(n);
        check("bp_data3", 32'(out_data), 32'h13);
        step();
        check("bp_done", 32'(done), 32'd1);
        step();
        check("bp_accepted", 32'(acc_d.size() - q0), 32'd4);
        for (int k = 0; k < 4; k++) check("bp_sb_data", 32'(acc_d[q0 + k]), 32'(8'h10 + k));

        // Address wrap
        q0 = acc_d.size();
        start_run(11'h7FE, 12'd4);
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            check("wrap_addr", 32'(address), 32'((11'h7FE + 11'(k)) & 11'h7FF));
            step();
        end
        check("wrap_done", 32'(done), 32'd1);
        step();
        check("wrap_sb_a0", 32'(acc_a[q0]), 32'h7FE);
        check("wrap_sb_a1", 32'(acc_a[q0 + 1]), 32'h7FF);
        check("wrap_sb_a2", 32'(acc_a[q0 + 2]), 32'h000);
        check("wrap_sb_a3", 32'(acc_a[q0 + 3]), 32'h001);
        check("wrap_sb_d0", 32'(acc_d[q0]), 32'h0E);
        check("wrap_sb_d2", 32'(acc_d[q0 + 2]), 32'h10);

        // Zero length
        q0 = acc_d.size();
        c0 = nce_low_cnt;
        d0 = done_cnt;
        start_run(11'h005, 12'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_nce", 32'(nce), 32'd1);
        check("zero_noe", 32'(noe), 32'd1);
        check("zero_valid", 32'(out_valid), 32'd0);
        step();
        check("zero_done_low", 32'(done), 32'd0);
        check("zero_busy_low", 32'(busy), 32'd0);
        step();
        check("zero_nce_cycles", 32'(nce_low_cnt - c0), 32'd0);
        check("zero_accepted", 32'(acc_d.size() - q0), 32'd0);
        check("zero_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset during ACCESS of sample 3
        d0 = done_cnt;
        start_run(11'h100, 12'd4);
        wait_valid(n);
        step();
        wait_valid(n);
        step();
        step();
        check("rstmid_in_access", 32'(noe), 32'd0);
        reset = 1'b1;
        #1;
        check("rstmid_nce", 32'(nce), 32'd1);
        check("rstmid_noe", 32'(noe), 32'd1);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        start_run(11'h200, 12'd2);
        wait_valid(n);
        check("rstmid_new_addr0", 32'(address), 32'h200);
        check("rstmid_new_data0", 32'(out_data), 32'h10);
        step();
        wait_valid(n);
        check("rstmid_new_addr1", 32'(address), 32'h201);
        check("rstmid_new_data1", 32'(out_data), 32'h11);
        step();
        check("rstmid_new_done", 32'(done), 32'd1);
        step();

        // Start while busy is ignored
        q0 = acc_d.size();
        start_run(11'h010, 12'd2);
        start     = 1'b1;
        base_addr = 11'h400;
        len       = 12'd3;
        step();
        start     = 1'b0;
        wait_valid(n);
        check("ign_addr0", 32'(address), 32'h010);
        check("ign_data0", 32'(out_data), 32'h20);
        step();
        wait_valid(n);
        check("ign_addr1", 32'(address), 32'h011);
        check("ign_data1", 32'(out_data), 32'h21);
        step();
        check("ign_done", 32'(done), 32'd1);
        step();
        step();
        step();
        step();
        check("ign_no_rerun", 32'(busy), 32'd0);
        check("ign_accepted", 32'(acc_d.size() - q0), 32'd2);

        check("strobe_invariant", 32'(strobe_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
